// File: rtl/cond_flag_unit.sv
// NZCV status register with multi-lane ARM condition evaluation and flag-hazard stall.
// Optional macro COND_FLAG_BYPASS_EN forwards writeback flags into same-cycle evaluation.
module cond_flag_unit #(
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned PEND_DEPTH = 3,
    parameter logic [3:0]  NZCV_RST   = 4'b0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_CH-1:0]     lane_valid,
    input  logic [4*NUM_CH-1:0]   lane_cond,
    input  logic                  set_issue,
    input  logic                  set_wb,
    input  logic [3:0]            wb_nzcv,
    input  logic                  flush,
    output logic [NUM_CH-1:0]     lane_check,
    output logic                  stall,
    output logic                  issue_full,
    output logic [3:0]            nzcv,
    output logic                  err
);

    localparam int unsigned CW = $clog2(PEND_DEPTH + 1);

    logic [CW-1:0] pend_cnt;
    logic [CW-1:0] pend_nxt;
    logic [CW-1:0] pend_eff;
    logic [3:0]    f_eff;
    logic          err_set;
    logic          hazard;

    // Evaluate a 4-bit ARM condition code against flags {N,Z,C,V}
    function automatic logic cond_true(input logic [3:0] code, input logic [3:0] f);
        logic n, z, c, v;
        {n, z, c, v} = f;
        case (code)
            4'h0:    cond_true = z;
            4'h1:    cond_true = !z;
            4'h2:    cond_true = c;
            4'h3:    cond_true = !c;
            4'h4:    cond_true = n;
            4'h5:    cond_true = !n;
            4'h6:    cond_true = v;
            4'h7:    cond_true = !v;
            4'h8:    cond_true = c && !z;
            4'h9:    cond_true = !c || z;
            4'hA:    cond_true = (n == v);
            4'hB:    cond_true = (n != v);
            4'hC:    cond_true = !z && (n == v);
            4'hD:    cond_true = z || (n != v);
            4'hE:    cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    endfunction

    // Effective flags/count seen by this cycle's evaluation
    always_comb begin
        f_eff    = nzcv;
        pend_eff = pend_cnt;
`ifdef COND_FLAG_BYPASS_EN
        if (set_wb) begin
            f_eff    = wb_nzcv;
            pend_eff = (pend_cnt == '0) ? '0 : pend_cnt - CW'(1);
        end
`endif
    end

    // Codes E/F are flag-independent; all lanes share one stall because they issue together
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (lane_valid[i] && (lane_cond[4*i +: 4] < 4'hE) && (pend_eff != '0))
                hazard = 1'b1;
        end
    end

    assign stall = hazard;

    always_comb begin
        lane_check = '0;
        for (int i = 0; i < int'(NUM_CH); i++)
            lane_check[i] = lane_valid[i] && cond_true(lane_cond[4*i +: 4], f_eff) && !hazard;
    end

    assign issue_full = (pend_cnt == CW'(PEND_DEPTH));

    // Pending-count next state: flush wins, then issue/writeback balance
    always_comb begin
        pend_nxt = pend_cnt;
        if (flush)
            pend_nxt = '0;
        else if (set_issue && set_wb)
            pend_nxt = pend_cnt;
        else if (set_issue && !issue_full)
            pend_nxt = pend_cnt + CW'(1);
        else if (set_wb && (pend_cnt != '0))
            pend_nxt = pend_cnt - CW'(1);
    end

    assign err_set = (set_issue && issue_full && !set_wb && !flush) ||
                     (set_wb && (pend_cnt == '0) && !set_issue);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nzcv     <= NZCV_RST;
            pend_cnt <= '0;
            err      <= 1'b0;
        end else begin
            if (set_wb)
                nzcv <= wb_nzcv;
            pend_cnt <= pend_nxt;
            if (err_set)
                err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cond_flag_unit.sv
// Directed table-driven bench for cond_flag_unit (NUM_CH=2, PEND_DEPTH=3, NZCV_RST=0).
module tb_cond_flag_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] lane_valid;
    logic [7:0] lane_cond;
    logic       set_issue, set_wb, flush;
    logic [3:0] wb_nzcv;
    logic [1:0] lane_check;
    logic       stall, issue_full, err;
    logic [3:0] nzcv;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cond_flag_unit #(.NUM_CH(2), .PEND_DEPTH(3), .NZCV_RST(4'b0000)) dut (
        .clk(clk), .rst_n(rst_n), .lane_valid(lane_valid), .lane_cond(lane_cond),
        .set_issue(set_issue), .set_wb(set_wb), .wb_nzcv(wb_nzcv), .flush(flush),
        .lane_check(lane_check), .stall(stall), .issue_full(issue_full),
        .nzcv(nzcv), .err(err)
    );

    typedef struct {
        logic [1:0] valid;
        logic [7:0] cond;
        logic       iss;
        logic       wb;
        logic [3:0] wbn;
        logic       fl;
        logic [1:0] ex_chk;
        logic       ex_stall;
        logic       ex_full;
        logic [3:0] ex_nzcv;
        logic       ex_err;
    } vec_t;

    vec_t tbl[16];

    function automatic vec_t mk(logic [1:0] valid, logic [7:0] cond, logic iss, logic wb,
                                logic [3:0] wbn, logic fl, logic [1:0] ex_chk,
                                logic ex_stall, logic ex_full, logic [3:0] ex_nzcv,
                                logic ex_err);
        vec_t v;
        v.valid = valid; v.cond = cond; v.iss = iss; v.wb = wb; v.wbn = wbn; v.fl = fl;
        v.ex_chk = ex_chk; v.ex_stall = ex_stall; v.ex_full = ex_full;
        v.ex_nzcv = ex_nzcv; v.ex_err = ex_err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] valid, input logic [7:0] cond, input logic iss,
                         input logic wb, input logic [3:0] wbn, input logic fl);
        lane_valid = valid; lane_cond = cond; set_issue = iss;
        set_wb = wb; wb_nzcv = wbn; flush = fl;
    endtask

    task automatic idle();
        drive(2'b00, 8'hEE, 1'b0, 1'b0, 4'h0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle();
        #1;
        chk("rst nzcv", 8'(nzcv), 8'h0);
        chk("rst err", 8'(err), 8'h0);
        chk("rst full", 8'(issue_full), 8'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic issue_n(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            drive(2'b00, 8'hEE, 1'b1, 1'b0, 4'h0, 1'b0);
        end
        @(negedge clk);
        idle();
    endtask

    initial begin
        // Rows are sampled before the edge; register expectations reflect earlier rows
        tbl[0]  = mk(2'b11, 8'hE0, 0, 0, 4'h0, 0, 2'b10, 0, 0, 4'h0, 0);
        tbl[1]  = mk(2'b00, 8'hEE, 0, 1, 4'h4, 0, 2'b00, 0, 0, 4'h0, 0);
        tbl[2]  = mk(2'b11, 8'h10, 0, 0, 4'h0, 0, 2'b01, 0, 0, 4'h4, 1);
        tbl[3]  = mk(2'b00, 8'hEE, 0, 1, 4'h8, 0, 2'b00, 0, 0, 4'h4, 1);
        tbl[4]  = mk(2'b11, 8'hCD, 0, 0, 4'h0, 0, 2'b01, 0, 0, 4'h8, 1);
        tbl[5]  = mk(2'b00, 8'hEE, 0, 1, 4'h6, 0, 2'b00, 0, 0, 4'h8, 1);
        tbl[6]  = mk(2'b11, 8'hF8, 0, 0, 4'h0, 0, 2'b00, 0, 0, 4'h6, 1);
        tbl[7]  = mk(2'b11, 8'h92, 0, 0, 4'h0, 0, 2'b11, 0, 0, 4'h6, 1);
        tbl[8]  = mk(2'b11, 8'hE2, 1, 0, 4'h0, 0, 2'b11, 0, 0, 4'h6, 1);
        tbl[9]  = mk(2'b11, 8'hE2, 1, 0, 4'h0, 0, 2'b00, 1, 0, 4'h6, 1);
        tbl[10] = mk(2'b10, 8'hE2, 1, 0, 4'h0, 0, 2'b10, 0, 0, 4'h6, 1);
        tbl[11] = mk(2'b00, 8'hEE, 0, 0, 4'h0, 0, 2'b00, 0, 1, 4'h6, 1);
        tbl[12] = mk(2'b00, 8'hEE, 1, 1, 4'h1, 0, 2'b00, 0, 1, 4'h6, 1);
        tbl[13] = mk(2'b01, 8'hE6, 0, 0, 4'h0, 0, 2'b00, 1, 1, 4'h1, 1);
        tbl[14] = mk(2'b00, 8'hEE, 0, 0, 4'h0, 1, 2'b00, 0, 1, 4'h1, 1);
        tbl[15] = mk(2'b01, 8'hE6, 0, 0, 4'h0, 0, 2'b01, 0, 0, 4'h1, 1);

        rst_n = 1'b0;
        idle();
        lane_valid = 2'b11;
        lane_cond  = 8'hE0;
        #1;
        chk("rst lane_check", 8'(lane_check), 8'h02);
        chk("rst stall", 8'(stall), 8'h0);
        chk("rst nzcv", 8'(nzcv), 8'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int r = 0; r < 16; r++) begin
            @(negedge clk);
            drive(tbl[r].valid, tbl[r].cond, tbl[r].iss, tbl[r].wb, tbl[r].wbn, tbl[r].fl);
            #1;
            chk($sformatf("row%0d lane_check", r), 8'(lane_check), 8'(tbl[r].ex_chk));
            chk($sformatf("row%0d stall", r), 8'(stall), 8'(tbl[r].ex_stall));
            chk($sformatf("row%0d issue_full", r), 8'(issue_full), 8'(tbl[r].ex_full));
            chk($sformatf("row%0d nzcv", r), 8'(nzcv), 8'(tbl[r].ex_nzcv));
            chk($sformatf("row%0d err", r), 8'(err), 8'(tbl[r].ex_err));
        end

        // Overflow: fourth issue at full sets err, count stays full
        do_reset();
        issue_n(3);
        #1;
        chk("ovf full", 8'(issue_full), 8'h1);
        chk("ovf err before", 8'(err), 8'h0);
        issue_n(1);
        #1;
        chk("ovf err", 8'(err), 8'h1);
        chk("ovf full after", 8'(issue_full), 8'h1);

        // Issue+writeback together at full is legal
        do_reset();
        issue_n(3);
        @(negedge clk);
        drive(2'b00, 8'hEE, 1'b1, 1'b1, 4'h5, 1'b0);
        @(negedge clk);
        idle();
        #1;
        chk("iss+wb full", 8'(issue_full), 8'h1);
        chk("iss+wb err", 8'(err), 8'h0);
        chk("iss+wb nzcv", 8'(nzcv), 8'h5);

        // Last writeback with a dependent EQ lane waiting
        do_reset();
        issue_n(1);
        @(negedge clk);
        drive(2'b01, 8'hE0, 1'b0, 1'b1, 4'h4, 1'b0);
        #1;
`ifdef COND_FLAG_BYPASS_EN
        chk("byp stall", 8'(stall), 8'h0);
        chk("byp check", 8'(lane_check), 8'h01);
`else
        chk("nobyp stall", 8'(stall), 8'h1);
        chk("nobyp check", 8'(lane_check), 8'h00);
`endif
        @(negedge clk);
        drive(2'b01, 8'hE0, 1'b0, 1'b0, 4'h0, 1'b0);
        #1;
        chk("wb next stall", 8'(stall), 8'h0);
        chk("wb next check", 8'(lane_check), 8'h01);
        chk("wb next nzcv", 8'(nzcv), 8'h4);
        chk("wb next err", 8'(err), 8'h0);

        // Flush with simultaneous writeback: flags land, count clears
        do_reset();
        issue_n(2);
        @(negedge clk);
        drive(2'b00, 8'hEE, 1'b0, 1'b1, 4'h8, 1'b1);
        @(negedge clk);
        drive(2'b01, 8'hE4, 1'b0, 1'b0, 4'h0, 1'b0);
        #1;
        chk("flush nzcv", 8'(nzcv), 8'h8);
        chk("flush stall", 8'(stall), 8'h0);
        chk("flush check", 8'(lane_check), 8'h01);
        chk("flush err", 8'(err), 8'h0);
        chk("flush full", 8'(issue_full), 8'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
